// File: rtl/frame_mem_responder.sv
// Frame memory responder: template/window banks served to the fabric at fixed read latency,
// host load port, per-set hand-off. Define FRAME_MEM_ERR_CNT_EN to add the err_count output.
module frame_mem_responder #(
  parameter int T_ROWS  = 16,
  parameter int T_WORDS = 4,
  parameter int W_ROWS  = 128,
  parameter int W_WORDS = 32,
  parameter int RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        rd_wr,
  input  logic        tem_win,
  input  logic [6:0]  row,
  input  logic [6:0]  col,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        rd_valid,
  input  logic        set_done,
  output logic        ready_2_start,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic [6:0]  load_row,
  input  logic [6:0]  load_col,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        load_ready,
  output logic        addr_err,
`ifdef FRAME_MEM_ERR_CNT_EN
  output logic [15:0] err_count,
`endif
  output logic [7:0]  set_count
);
  localparam int DATA_W  = 32;
  localparam int T_DEPTH = T_ROWS * T_WORDS;
  localparam int W_DEPTH = W_ROWS * W_WORDS;
  localparam int TA_W    = (T_DEPTH > 1) ? $clog2(T_DEPTH) : 1;
  localparam int WA_W    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_e;

  function automatic logic t_legal(input logic [6:0] r, input logic [6:0] c);
    return (int'(r) < T_ROWS) && (int'(c) < T_WORDS);
  endfunction

  function automatic logic w_legal(input logic [6:0] r, input logic [6:0] c);
    return (int'(r) < W_ROWS) && (int'(c) < W_WORDS);
  endfunction

  function automatic logic [TA_W-1:0] t_addr(input logic [6:0] r, input logic [6:0] c);
    return TA_W'(int'(r) * T_WORDS + int'(c));
  endfunction

  function automatic logic [WA_W-1:0] w_addr(input logic [6:0] r, input logic [6:0] c);
    return WA_W'(int'(r) * W_WORDS + int'(c));
  endfunction

  logic [DATA_W-1:0] t_bank [T_DEPTH];
  logic [DATA_W-1:0] w_bank [W_DEPTH];

  state_e            state_q, state_d;
  logic [7:0]        set_count_q, set_count_d;
  logic              addr_err_q, addr_err_d;
  logic [DATA_W-1:0] read_data_q;
  logic              rd_valid_q;

  logic              f_rd, f_wr, f_t_ok, f_w_ok, f_ok;
  logic              h_t_ok, h_w_ok, h_ok, err_evt;
  logic [TA_W-1:0]   f_t_addr, h_t_addr, t_waddr;
  logic [WA_W-1:0]   f_w_addr, h_w_addr, w_waddr;
  logic              t_we, w_we;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word_p0;
  logic [DATA_W-1:0] data_st;
  logic              vld_st;

  // Decode: out-of-range addresses never reach a bank index, so they cannot alias.
  assign f_rd     = req & ~rd_wr;
  assign f_wr     = req & rd_wr;
  assign f_t_ok   = t_legal(row, col);
  assign f_w_ok   = w_legal(row, col);
  assign f_ok     = tem_win ? f_w_ok : f_t_ok;
  assign f_t_addr = f_t_ok ? t_addr(row, col) : '0;
  assign f_w_addr = f_w_ok ? w_addr(row, col) : '0;

  assign h_t_ok   = t_legal(load_row, load_col);
  assign h_w_ok   = w_legal(load_row, load_col);
  assign h_ok     = load_sel ? h_w_ok : h_t_ok;
  assign h_t_addr = h_t_ok ? t_addr(load_row, load_col) : '0;
  assign h_w_addr = h_w_ok ? w_addr(load_row, load_col) : '0;

  // Host is only granted when the fabric is silent, so one write port per bank suffices.
  assign load_ready = load_en & ~req & (state_q == IDLE);

  assign t_we    = (f_wr & ~tem_win & f_t_ok) | (load_ready & ~load_sel & h_t_ok);
  assign w_we    = (f_wr & tem_win & f_w_ok) | (load_ready & load_sel & h_w_ok);
  assign t_waddr = req ? f_t_addr : h_t_addr;
  assign w_waddr = req ? f_w_addr : h_w_addr;
  assign wr_data = req ? write_data : load_data;

  assign err_evt = (req & ~f_ok) | (load_ready & ~h_ok);

  always_ff @(posedge clk) begin
    if (t_we) t_bank[t_waddr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (w_we) w_bank[w_waddr] <= wr_data;
  end

  // Stage p0: bank lookup, illegal reads forced to zero
  always_comb begin
    rd_word_p0 = '0;
    if (f_ok) rd_word_p0 = tem_win ? w_bank[f_w_addr] : t_bank[f_t_addr];
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] rd_data_p1_q;
    logic              vld_p1_q;

    // Stage p1: extra latency register
    always_ff @(posedge clk) begin
      if (rst) vld_p1_q <= 1'b0;
      else     vld_p1_q <= f_rd;
    end

    always_ff @(posedge clk) begin
      rd_data_p1_q <= rd_word_p0;
    end

    assign vld_st  = vld_p1_q;
    assign data_st = rd_data_p1_q;
  end else begin : g_lat1
    assign vld_st  = f_rd;
    assign data_st = rd_word_p0;
  end

  // Output stage: read_data only moves when a result lands
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      rd_valid_q <= vld_st;
      if (vld_st) read_data_q <= data_st;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      set_count_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_count_q <= set_count_d;
      addr_err_q  <= addr_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_count_d = set_count_q;
    addr_err_d  = addr_err_q | err_evt;
    case (state_q)
      IDLE:  if (load_done) state_d = ARMED;
      ARMED: if (req) state_d = RUN;
      RUN: begin
        if (set_done) begin
          state_d     = IDLE;
          set_count_d = set_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FRAME_MEM_ERR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_evt) err_count_d = sat_inc16(err_count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

  assign read_data     = read_data_q;
  assign rd_valid      = rd_valid_q;
  assign ready_2_start = (state_q == ARMED);
  assign addr_err      = addr_err_q;
  assign set_count     = set_count_q;

endmodule

// File: tb/tb_frame_mem_responder.sv
// Randomized scoreboard bench for frame_mem_responder: a monitor pops expected read results
// and checks data and arrival cycle; control outputs are checked against a phase model.
module tb_frame_mem_responder;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst, req, rd_wr, tem_win, set_done, load_en, load_sel, load_done;
  logic [6:0]  row, col, load_row, load_col;
  logic [31:0] write_data, load_data, read_data;
  logic        rd_valid, ready_2_start, load_ready, addr_err;
  logic [7:0]  set_count;
`ifdef FRAME_MEM_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  always #5 clk = ~clk;

  frame_mem_responder #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .rd_wr(rd_wr), .tem_win(tem_win),
    .row(row), .col(col), .write_data(write_data), .read_data(read_data),
    .rd_valid(rd_valid), .set_done(set_done), .ready_2_start(ready_2_start),
    .load_en(load_en), .load_sel(load_sel), .load_row(load_row), .load_col(load_col),
    .load_data(load_data), .load_done(load_done), .load_ready(load_ready),
    .addr_err(addr_err),
`ifdef FRAME_MEM_ERR_CNT_EN
    .err_count(err_count),
`endif
    .set_count(set_count)
  );

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] tm [16][4];
  logic [31:0] wm [128][32];
  int phase = 0;      // 0 idle, 1 armed, 2 running a set
  int m_sets = 0;
  int m_err_cnt = 0;
  bit m_addr_err = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t m;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      m = sb_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL rd_missing: no rd_valid by cycle %0d, expected data %h at cycle %0d", cyc, m.data, m.cyc);
    end
    if (rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: rd_valid=1 data %h at cycle %0d, required no result", read_data, cyc);
      end else begin
        m = sb_q.pop_front();
        chk("rd_data", read_data, m.data);
        chk("rd_cycle", 32'(cyc), 32'(m.cyc));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input bit tw, input int r, input int c);
    return tw ? (r < 128 && c < 32) : (r < 16 && c < 4);
  endfunction

  task automatic note_err();
    m_addr_err = 1;
    if (m_err_cnt < 65535) m_err_cnt++;
  endtask

  task automatic fab(input bit wr, input bit tw, input int r, input int c, input logic [31:0] d);
    exp_t e;
    bit ok;
    ok = legal(tw, r, c);
    req = 1; rd_wr = wr; tem_win = tw; row = 7'(r); col = 7'(c); write_data = d;
    if (!ok) note_err();
    if (!wr) begin
      e.data = !ok ? 32'h0 : (tw ? wm[r][c] : tm[r][c]);
      e.cyc  = cyc + RD_LAT;
      sb_q.push_back(e);
    end else if (ok) begin
      if (tw) wm[r][c] = d; else tm[r][c] = d;
    end
    if (phase == 1) phase = 2;
    tick();
  endtask

  task automatic host_load(input bit sel, input int r, input int c, input logic [31:0] d);
    bit done;
    done = 0;
    req = 0; load_en = 1; load_sel = sel; load_row = 7'(r); load_col = 7'(c); load_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      #2;
      if (load_ready === 1'b1) begin
        done = 1;
        if (legal(sel, r, c)) begin
          if (sel) wm[r][c] = d; else tm[r][c] = d;
        end else note_err();
      end
      tick();
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL host_load_timeout: load_ready never 1 for sel %0d row %0d col %0d", sel, r, c);
    end
    load_en = 0;
  endtask

  task automatic load_done_pulse();
    req = 0; load_done = 1;
    if (phase == 0) phase = 1;
    tick();
    load_done = 0;
  endtask

  task automatic set_done_pulse();
    req = 0; set_done = 1;
    if (phase == 2) begin phase = 0; m_sets = (m_sets + 1) % 256; end
    tick();
    set_done = 0;
  endtask

  task automatic chk_ctrl(input string nm);
    chk({nm, "_ready_2_start"}, 32'(ready_2_start), 32'(phase == 1));
    chk({nm, "_set_count"}, 32'(set_count), 32'(m_sets));
    chk({nm, "_addr_err"}, 32'(addr_err), 32'(m_addr_err));
`ifdef FRAME_MEM_ERR_CNT_EN
    chk({nm, "_err_count"}, 32'(err_count), 32'(m_err_cnt));
`endif
  endtask

  initial begin
    int op, r, c;
    bit tw;
    rst = 1; req = 0; rd_wr = 0; tem_win = 0; row = 0; col = 0; write_data = 0;
    set_done = 0; load_en = 0; load_sel = 0; load_row = 0; load_col = 0; load_data = 0;
    load_done = 0;
    repeat (3) tick();
    chk("reset_read_data", read_data, 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_load_ready", 32'(load_ready), 32'h0);
    chk_ctrl("reset");
    rst = 0;
    tick();

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) host_load(0, i, j, $urandom);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 32; j++) host_load(1, i, j, (i == 5 && j < 16) ? 32'(j) : $urandom);
    host_load(0, 3, 2, 32'hA1B2C3D4);
    chk_ctrl("idle_loaded");

    load_done_pulse();
    chk_ctrl("armed");
    load_en = 1; load_sel = 0; load_row = 0; load_col = 0;
    #2;
    chk("load_ready_armed", 32'(load_ready), 32'h0);
    load_en = 0;
    fab(0, 0, 3, 2, 0);
    chk_ctrl("run_entered");

    for (int j = 0; j < 16; j++) fab(0, 1, 5, j, 0);
    fab(1, 1, 2, 1, 32'h0000BEEF);
    fab(0, 1, 2, 1, 0);
    req = 0;
    tick();

    fab(1, 0, 0, 5, 32'hDEADBEEF);
    fab(0, 0, 1, 1, 0);
    fab(0, 0, 16, 0, 0);
    req = 0;
    tick();
    chk_ctrl("illegal");

    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 9);
      tw = 1'($urandom_range(0, 1));
      if (op <= 6) begin
        r = tw ? $urandom_range(0, 7) : $urandom_range(0, 15);
        c = tw ? $urandom_range(0, 31) : $urandom_range(0, 3);
        fab(op >= 4, tw, r, c, $urandom);
      end else if (op == 7) begin
        req = 0;
        tick();
      end else begin
        if (tw) begin
          r = $urandom_range(0, 127); c = $urandom_range(32, 127);
        end else if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(16, 127); c = $urandom_range(0, 3);
        end else begin
          r = $urandom_range(0, 15); c = $urandom_range(4, 127);
        end
        fab(op == 9, tw, r, c, $urandom);
      end
    end
    req = 0;
    tick();
    chk_ctrl("random");
    set_done_pulse();
    chk_ctrl("set_ended");

    load_en = 1; load_sel = 0; load_row = 7; load_col = 0; load_data = 32'h55AA33CC;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      req = 1; rd_wr = 0; tem_win = 0; row = 7; col = 0;
      e.data = tm[7][0]; e.cyc = cyc + RD_LAT;
      sb_q.push_back(e);
      #2;
      chk("load_ready_blocked", 32'(load_ready), 32'h0);
      tick();
    end
    req = 0;
    #2;
    chk("load_ready_granted", 32'(load_ready), 32'h1);
    tm[7][0] = 32'h55AA33CC;
    tick();
    load_en = 0;
    fab(0, 0, 7, 0, 0);
    host_load(0, 20, 0, 32'hFFFF0000);
    fab(0, 0, 4, 0, 0);
    req = 0;
    tick();
    chk_ctrl("arbitration");

    load_done_pulse();
    fab(0, 0, 3, 2, 0);
    chk_ctrl("run_again");
    req = 1; rd_wr = 0; tem_win = 0; row = 3; col = 2; rst = 1;
    tick();
    req = 0;
    tick();
    rst = 0;
    phase = 0; m_sets = 0; m_addr_err = 0; m_err_cnt = 0;
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk_ctrl("after_rst");
    fab(0, 0, 3, 2, 0);
    host_load(1, 6, 0, 32'h12345678);
    fab(0, 1, 6, 0, 0);
    req = 0;
    tick();

    for (int i = 0; i < 256; i++) begin
      load_done_pulse();
      fab(0, 0, i % 16, i % 4, 0);
      if (i % 2 == 1) begin
        set_done = 1;
        fab(0, 1, i % 8, i % 32, 0);
        set_done = 0;
        phase = 0;
        m_sets = (m_sets + 1) % 256;
      end else begin
        set_done_pulse();
      end
      if (i == 254) chk_ctrl("sets_255");
    end
    req = 0;
    tick();
    chk_ctrl("sets_wrapped");
    chk("set_count_zero", 32'(set_count), 32'h0);

    repeat (RD_LAT + 3) tick();
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
